multi_btn_filter: RTL and testbench

Parametrised N-channel push-button debouncer replacing the single-channel filter. Each channel synchronises an asynchronous raw button, qualifies every level change by a stable-time counter, and delivers a clean level plus single-cycle press/release pulses. Sits directly behind the board button pins and feeds the control FSMs and counters of the lab top level. An optional long-press detector is compiled in by macro.

---
 rtl/btn_filter_pkg.sv | 13 +
 rtl/btn_filter_chan.sv | 112 +++++++++++
 rtl/multi_btn_filter.sv | 38 +++
 tb/tb_multi_btn_filter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_filter_pkg.sv
// Shared constants and helpers for the push-button filter family.
package btn_filter_pkg;

    localparam int unsigned BTN_DEBOUNCE_DEFAULT = 10000;
    localparam int unsigned BTN_LONG_DEFAULT     = 1000000;
    localparam logic        BTN_PRESSED          = 1'b1;

    // Bits needed to hold 0..max_count; never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/btn_filter_chan.sv
// One debounce channel: 2-flop synchroniser, stable counter, level and edge pulses.
// Optional hold counter for long-press detection under MULTI_BTN_FILTER_LONG_PRESS_EN.
module btn_filter_chan
    import btn_filter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int unsigned LONG_CYCLES     = BTN_LONG_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("LONG_CYCLES must be at least 1");
    end

    localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync0_q;
    logic            sync_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            state_q;
    logic            state_d;
    logic            accept;
    logic            press_q;
    logic            release_q;

    // Any cycle where the synchronised level matches the accepted one restarts the window.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        accept  = 1'b0;
        if (sync_q == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            accept  = 1'b1;
            state_d = ~state_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync0_q   <= 1'b0;
            sync_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync0_q   <= raw_i;
            sync_q    <= sync0_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= accept && (state_d == BTN_PRESSED);
            release_q <= accept && (state_d != BTN_PRESSED);
        end
    end

    assign state_o   = state_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef MULTI_BTN_FILTER_LONG_PRESS_EN
    localparam int unsigned      HoldW   = cnt_width(LONG_CYCLES);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES);

    logic [HoldW-1:0] hold_q;
    logic [HoldW-1:0] hold_d;
    logic             long_q;
    logic             long_d;

    // Saturating at HoldMax is what limits the pulse to once per press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (state_q != BTN_PRESSED) begin
            hold_d = '0;
        end else if (hold_q != HoldMax) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_d == HoldMax);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/multi_btn_filter.sv
// N-channel push-button debouncer built from independent btn_filter_chan slices.
// Long-press pulses are compiled in only when MULTI_BTN_FILTER_LONG_PRESS_EN is defined.
module multi_btn_filter
    import btn_filter_pkg::*;
#(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int unsigned LONG_CYCLES     = BTN_LONG_DEFAULT
) (
    input  logic            clockSource,
    input  logic            reset,
    input  logic [N_CH-1:0] rawButton,
    output logic [N_CH-1:0] currentState,
    output logic [N_CH-1:0] pressPulse,
    output logic [N_CH-1:0] releasePulse,
    output logic [N_CH-1:0] longPress
);

    if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
        $error("N_CH must be in 1..32");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        btn_filter_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_chan (
            .clk_i    (clockSource),
            .rst_i    (reset),
            .raw_i    (rawButton[i]),
            .state_o  (currentState[i]),
            .press_o  (pressPulse[i]),
            .release_o(releasePulse[i]),
            .long_o   (longPress[i])
        );
    end

endmodule

// File: tb/tb_multi_btn_filter.sv
// Directed bench for multi_btn_filter: 4 channels at DEBOUNCE_CYCLES=8 plus a 1-channel
// instance at DEBOUNCE_CYCLES=1.
module tb_multi_btn_filter;

`ifdef MULTI_BTN_FILTER_LONG_PRESS_EN
    localparam bit LongEn = 1'b1;
`else
    localparam bit LongEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] raw;
    logic [3:0] st;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] lg;
    logic [0:0] raw1;
    logic [0:0] st1;
    logic [0:0] pr1;
    logic [0:0] rl1;
    logic [0:0] lg1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_btn_filter #(
        .N_CH           (4),
        .DEBOUNCE_CYCLES(8),
        .LONG_CYCLES    (20)
    ) dut (
        .clockSource (clk),
        .reset       (rst),
        .rawButton   (raw),
        .currentState(st),
        .pressPulse  (pr),
        .releasePulse(rl),
        .longPress   (lg)
    );

    multi_btn_filter #(
        .N_CH           (1),
        .DEBOUNCE_CYCLES(1),
        .LONG_CYCLES    (2)
    ) dut1 (
        .clockSource (clk),
        .reset       (rst),
        .rawButton   (raw1),
        .currentState(st1),
        .pressPulse  (pr1),
        .releasePulse(rl1),
        .longPress   (lg1)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] est, input logic [3:0] epr,
                              input logic [3:0] erl, input logic [3:0] elg);
        chk({tag, " state"}, st, est);
        chk({tag, " press"}, pr, epr);
        chk({tag, " release"}, rl, erl);
        chk({tag, " long"}, lg, elg);
    endtask

    initial begin
        rst  = 1'b1;
        raw  = 4'b0000;
        raw1 = 1'b0;
        tick(3);
        expect_out("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;

        // Clean step on ch0: accepted 2 + 8 clocks later.
        raw = 4'b0001;
        tick(9);
        expect_out("step_pre", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_out("step_edge", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        tick(1);
        expect_out("step_post", 4'b0001, 4'b0000, 4'b0000, 4'b0000);

        // ch1 bounces every 3 clocks for 30 clocks, then holds high.
        for (int k = 0; k < 10; k++) begin
            raw[1] = (k % 2 == 0);
            tick(3);
            expect_out("bounce", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        end
        raw[1] = 1'b1;
        tick(9);
        expect_out("bounce_pre", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_out("bounce_edge", 4'b0011, 4'b0010, 4'b0000, 4'b0000);
        tick(1);
        expect_out("bounce_post", 4'b0011, 4'b0000, 4'b0000, 4'b0000);

        // 7-clock glitch on ch2 is rejected.
        raw[2] = 1'b1;
        tick(7);
        raw[2] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            expect_out("glitch7", 4'b0011, 4'b0000, 4'b0000, 4'b0000);
        end

        // 8-clock pulse on ch2 is the shortest accepted press.
        raw[2] = 1'b1;
        tick(8);
        raw[2] = 1'b0;
        tick(1);
        expect_out("pulse8_pre", 4'b0011, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_out("pulse8_press", 4'b0111, 4'b0100, 4'b0000, 4'b0000);
        tick(7);
        expect_out("pulse8_hold", 4'b0111, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_out("pulse8_release", 4'b0011, 4'b0000, 4'b0100, 4'b0000);
        tick(1);
        expect_out("pulse8_post", 4'b0011, 4'b0000, 4'b0000, 4'b0000);

        // Release everything, then press all four together.
        raw = 4'b0000;
        tick(10);
        expect_out("rel_all", 4'b0000, 4'b0000, 4'b0011, 4'b0000);
        tick(1);
        raw = 4'b1111;
        tick(9);
        expect_out("simul_pre", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_out("simul_edge", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        tick(1);
        expect_out("simul_post", 4'b1111, 4'b0000, 4'b0000, 4'b0000);

        // Asynchronous reset while all pressed: cleared at once, no release pulse.
        #3;
        rst = 1'b1;
        #1;
        expect_out("rst_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(2);
        expect_out("rst_held", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        tick(9);
        expect_out("rst_re_pre", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_out("rst_re_edge", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        tick(1);

        // Reset 5 clocks into a count on ch0; fresh full-latency press afterwards.
        raw = 4'b0000;
        tick(10);
        expect_out("rel_all2", 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        tick(1);
        raw = 4'b0001;
        tick(5);
        #3;
        rst = 1'b1;
        #1;
        expect_out("rst_mid", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        rst = 1'b0;
        tick(9);
        expect_out("rst_mid_pre", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_out("rst_mid_edge", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        tick(1);

        // Long hold on ch3: pulse 20 clocks after press (feature build only), once.
        raw = 4'b1001;
        tick(10);
        expect_out("long_press", 4'b1001, 4'b1000, 4'b0000, 4'b0000);
        tick(19);
        expect_out("long_pre", 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_out("long_edge", 4'b1001, 4'b0000, 4'b0000, LongEn ? 4'b1000 : 4'b0000);
        tick(1);
        expect_out("long_post", 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        tick(20);
        expect_out("long_once", 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        raw = 4'b0001;
        tick(10);
        expect_out("long_rel", 4'b0001, 4'b0000, 4'b1000, 4'b0000);
        tick(1);

        // Accepted release 15 clocks after press: no long pulse.
        raw = 4'b1001;
        tick(10);
        expect_out("short_press", 4'b1001, 4'b1000, 4'b0000, 4'b0000);
        tick(5);
        raw = 4'b0001;
        tick(9);
        expect_out("short_hold", 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_out("short_rel", 4'b0001, 4'b0000, 4'b1000, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            tick(1);
            expect_out("short_nolong", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        end

        // DEBOUNCE_CYCLES = 1: state one clock behind the synchroniser.
        raw1 = 1'b1;
        tick(2);
        chk("d1_pre state", {3'b000, st1}, 4'b0000);
        tick(1);
        chk("d1_edge state", {3'b000, st1}, 4'b0001);
        chk("d1_edge press", {3'b000, pr1}, 4'b0001);
        tick(1);
        chk("d1_post press", {3'b000, pr1}, 4'b0000);
        raw1 = 1'b0;
        tick(3);
        chk("d1_rel state", {3'b000, st1}, 4'b0000);
        chk("d1_rel release", {3'b000, rl1}, 4'b0001);
        tick(1);
        chk("d1_rel_post release", {3'b000, rl1}, 4'b0000);
        chk("d1_long idle", {3'b000, lg1}, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
